// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// apb_pkg : APB state encoding and default widths shared by master and slave
// Revision: 1.0
// ============================================================================
package apb_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] APB_IDLE   = 2'b00;
  localparam logic [1:0] APB_SETUP  = 2'b01;
  localparam logic [1:0] APB_ACCESS = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = APB_IDLE,
    ST_SETUP  = APB_SETUP,
    ST_ACCESS = APB_ACCESS
  } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// apb_wait_timer : counts ACCESS wait cycles, flags expiry; TIMEOUT_CYCLES=0 disables
// Revision: 1.0
// ============================================================================
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WAIT_CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      localparam logic [WAIT_CNT_WIDTH-1:0] C_LIMIT = WAIT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
      logic [WAIT_CNT_WIDTH-1:0] r_count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (count_en) begin
          r_count <= r_count + WAIT_CNT_WIDTH'(1);
        end
      end

      // Fires on the cycle whose edge would bring the count up to the limit
      assign expired = count_en && (r_count == C_LIMIT);
    end else begin : g_no_timeout
      assign expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// apb_master_bridge : valid/ready command port to APB master with bounded wait
// Revision: 1.0
// ============================================================================
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WAIT_CNT_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  apb_state_t r_state;
  apb_state_t w_next_state;
  logic       w_accept;
  logic       w_done;
  logic       w_expired;
  logic       w_wait_en;
  logic       w_wait_clr;

  // presetn is active-high despite its name
  assign req_ready  = (r_state == ST_IDLE) && !presetn;
  assign w_accept   = req_valid && req_ready;
  assign w_done     = (r_state == ST_ACCESS) && pready;
  assign w_wait_en  = (r_state == ST_ACCESS) && !pready;
  assign w_wait_clr = (r_state != ST_ACCESS);

  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .WAIT_CNT_WIDTH (WAIT_CNT_WIDTH)
  ) u_wait_timer (
    .clk      (pclk),
    .rst      (presetn),
    .clear    (w_wait_clr),
    .count_en (w_wait_en),
    .expired  (w_expired)
  );

  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_SETUP;
      ST_SETUP:  w_next_state = ST_ACCESS;
      ST_ACCESS: if (w_done || w_expired) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // APB strobes come from the next state so they are registered, not decoded
  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      psel        <= (w_next_state != ST_IDLE);
      penable     <= (w_next_state == ST_ACCESS);
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      if (w_accept) begin
        pwrite <= req_write;
        paddr  <= req_addr;
        pwdata <= req_write ? req_wdata : '0;
      end
      if (w_done) begin
        rsp_valid <= 1'b1;
        if (!pwrite) begin
          rsp_rdata <= prdata;
        end
      end else if (w_expired) begin
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// tb_apb_master_bridge : directed self-checking bench for apb_master_bridge
// Revision: 1.0
// ============================================================================
module tb_apb_master_bridge;

  logic        pclk;
  logic        presetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  int n_checks;
  int n_fail;

  apb_master_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16),
    .WAIT_CNT_WIDTH (8)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a command at a falling edge; returns at the next falling edge (SETUP)
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(negedge pclk);
    req_valid = 1'b0;
  endtask

  logic [31:0] addr_tab [9];
  logic [31:0] exp_tab  [3];
  int          acc_cnt;
  int          rsp_seen;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    presetn   = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    addr_tab  = '{32'h1, 32'hF1, 32'hF2, 32'h2, 32'hF3, 32'hF4, 32'h3, 32'hF5, 32'hF6};
    exp_tab   = '{32'h1, 32'h2, 32'h3};

    repeat (3) @(negedge pclk);
    check("rst_req_ready", req_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr, 0);
    presetn = 1'b0;
    @(negedge pclk);
    check("idle_req_ready", req_ready, 1);

    // 1: write, pready high early (must not shorten SETUP)
    pready = 1'b1;
    issue(1'b1, 32'h5, 32'hDEADBEEF);
    check("t1_setup_psel", psel, 1);
    check("t1_setup_penable", penable, 0);
    check("t1_setup_ready", req_ready, 0);
    check("t1_setup_paddr", paddr, 32'h5);
    check("t1_setup_pwdata", pwdata, 32'hDEADBEEF);
    @(negedge pclk);
    check("t1_access_psel", psel, 1);
    check("t1_access_penable", penable, 1);
    check("t1_access_pwrite", pwrite, 1);
    check("t1_access_rsp", rsp_valid, 0);
    @(negedge pclk);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_timeout", rsp_timeout, 0);
    check("t1_psel_drop", psel, 0);
    check("t1_ready_back", req_ready, 1);
    @(negedge pclk);
    check("t1_rsp_pulse", rsp_valid, 0);

    // 2: read returning DEADBEEF
    prdata = 32'hDEADBEEF;
    issue(1'b0, 32'h5, 32'h11111111);
    check("t2_setup_pwrite", pwrite, 0);
    check("t2_setup_pwdata", pwdata, 0);
    @(negedge pclk);
    check("t2_access_pwdata", pwdata, 0);
    @(negedge pclk);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    @(negedge pclk);
    check("t2_rsp_pulse", rsp_valid, 0);

    // 3: read with four wait states
    pready = 1'b0;
    prdata = 32'h12345678;
    issue(1'b0, 32'h9, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check("t3_psel", psel, 1);
      check("t3_penable", penable, 1);
      check("t3_paddr", paddr, 32'h9);
      check("t3_no_rsp", rsp_valid, 0);
      if (i == 4) pready = 1'b1;
    end
    @(negedge pclk);
    pready = 1'b0;
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_rdata", rsp_rdata, 32'h12345678);
    check("t3_rsp_timeout", rsp_timeout, 0);

    // 4: write with pready stuck low -> timeout after 16 ACCESS cycles
    @(negedge pclk);
    issue(1'b1, 32'h20, 32'hCAFEF00D);
    acc_cnt  = 0;
    rsp_seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      if (psel && penable) acc_cnt++;
      if (rsp_valid) rsp_seen++;
    end
    check("t4_access_cycles", acc_cnt, 16);
    check("t4_no_early_rsp", rsp_seen, 0);
    @(negedge pclk);
    check("t4_psel_drop", psel, 0);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_timeout", rsp_timeout, 1);
    check("t4_rsp_rdata", rsp_rdata, 0);
    check("t4_req_ready", req_ready, 1);
    @(negedge pclk);
    check("t4_rsp_pulse", rsp_valid, 0);

    // 5: asynchronous reset mid-ACCESS
    issue(1'b0, 32'h30, 32'h0);
    @(negedge pclk);
    check("t5_in_access", penable, 1);
    #2 presetn = 1'b1;
    #1;
    check("t5_async_psel", psel, 0);
    check("t5_async_penable", penable, 0);
    check("t5_async_rsp", rsp_valid, 0);
    @(negedge pclk);
    presetn = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      if (rsp_valid || psel) rsp_seen++;
    end
    check("t5_no_ghost_rsp", rsp_seen, 0);
    prdata = 32'hA5A5A5A5;
    pready = 1'b1;
    issue(1'b0, 32'h31, 32'h0);
    check("t5_setup_paddr", paddr, 32'h31);
    @(negedge pclk);
    @(negedge pclk);
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);

    // 6: req_valid held high, address changing every cycle
    prdata    = 32'h77;
    req_write = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      req_addr = addr_tab[c];
      check($sformatf("t6_ready_c%0d", c), req_ready, (c % 3) == 0);
      if (c >= 3 && (c % 3) == 0) check($sformatf("t6_rsp_c%0d", c), rsp_valid, 1);
      @(negedge pclk);
      check($sformatf("t6_paddr_c%0d", c), paddr, exp_tab[c / 3]);
      check($sformatf("t6_psel_c%0d", c), psel, (c % 3) != 2);
      check($sformatf("t6_penable_c%0d", c), penable, (c % 3) == 1);
    end
    req_valid = 1'b0;
    check("t6_last_rsp", rsp_valid, 1);
    check("t6_last_rdata", rsp_rdata, 32'h77);
    @(negedge pclk);
    check("t6_idle", psel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester that drives the team's APB slave memory.
- Accepts single read/write commands on a valid/ready request port.
- Runs the full APB IDLE -> SETUP -> ACCESS sequence and waits on pready, with a bounded wait.
- Returns read data and completion status on a one-cycle response strobe.

Parameters:
ADDR_WIDTH, 32, width of req_addr and paddr
DATA_WIDTH, 32, width of write/read data paths
TIMEOUT_CYCLES, 16, max ACCESS cycles with pready=0 before abort; 0 disables timeout
WAIT_CNT_WIDTH, 8, width of the ACCESS wait counter; must hold TIMEOUT_CYCLES

Ports:
pclk  input  1  APB clock; all logic rising-edge
presetn  input  1  asynchronous reset, active-high (asserted = 1), despite the name
req_valid  input  1  command present
req_ready  output  1  bridge can accept a command
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  transfer address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle completion strobe
rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid on reads
rsp_timeout  output  1  transfer aborted by timeout, valid with rsp_valid
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB slave ready

Behaviour:
- Reset (async, presetn=1):
  - Outputs: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_timeout all 0; req_ready 0 while reset is asserted.
  - State returns to IDLE and the wait counter clears.
  - A transfer cut off mid-flight produces no response.
- States: IDLE, SETUP, ACCESS; encoding is 2 bits, values 0/1/2.
- IDLE:
  - req_ready=1, psel=0, penable=0.
  - On a rising edge with req_valid && req_ready: register req_write/req_addr/req_wdata into pwrite/paddr/pwdata, then go to SETUP.
  - For reads, pwdata is registered as 0.
- SETUP:
  - psel=1, penable=0, req_ready=0.
  - Lasts exactly one cycle, then ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1, req_ready=0.
  - paddr, pwrite and pwdata stay stable from SETUP until the transfer ends.
- ACCESS with pready=1 at the edge:
  - Transfer completes; next state is IDLE and psel/penable drop to 0 in the next cycle.
  - Next cycle: rsp_valid=1 and rsp_timeout=0.
  - rsp_rdata = prdata sampled at that edge for reads; rsp_rdata unchanged for writes.
- ACCESS with pready=0:
  - The wait counter increments each cycle.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, abort:
    - next state is IDLE;
    - next cycle rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
  - The counter clears on leaving ACCESS.
- rsp_valid is a single-cycle pulse. It is registered and coincides with the first IDLE cycle, so req_ready=1 in the same cycle.
- Throughput: minimum 3 cycles per transfer (IDLE accept, SETUP, ACCESS). No back-to-back SETUP from ACCESS.
- Request sampling: req_valid is ignored outside IDLE. Request fields are sampled only on acceptance, so later changes to req_* do not affect the transfer in flight.
- pready is ignored outside ACCESS. A pready pulse during SETUP does not shorten the transfer.
- pslverr is not supported; the timeout is the only error indication.
- All APB outputs are registered; no combinational path from pready to psel/penable.

Decomposition:
- Shared package apb_pkg:
  - state encoding constants APB_IDLE=2'b00, APB_SETUP=2'b01, APB_ACCESS=2'b10, shared with the APB slave;
  - default ADDR_WIDTH/DATA_WIDTH constants.
- One natural sub-module: apb_wait_timer.
  - Inputs: clear, count enable, TIMEOUT_CYCLES parameter.
  - Output: expired flag.
  - Holds the counter and its zero-disables logic.
- The FSM and the datapath registers stay in apb_master_bridge.

Test Plan:
1. Write, pready=1 on the first ACCESS cycle: req addr=0x5, wdata=0xDEADBEEF.
   -> SETUP one cycle (psel=1, penable=0), ACCESS one cycle with pwrite=1, paddr=5, pwdata=0xDEADBEEF.
   -> rsp_valid pulse 3 cycles after acceptance, rsp_timeout=0.
2. Read addr=0x5, slave returns prdata=0xDEADBEEF with pready=1.
   -> rsp_rdata=0xDEADBEEF, rsp_valid one cycle, pwdata=0 throughout.
3. Read with pready held 0 for 4 ACCESS cycles, then 1, prdata=0x12345678.
   -> paddr, psel and penable stable all 5 ACCESS cycles; rsp_rdata=0x12345678, rsp_timeout=0.
4. Write with pready stuck 0, TIMEOUT_CYCLES=16.
   -> after 16 ACCESS cycles, psel=0 next cycle, rsp_valid=1, rsp_timeout=1, rsp_rdata=0; then req_ready=1.
5. Assert presetn=1 asynchronously mid-ACCESS.
   -> psel, penable and rsp_valid go to 0 immediately, with no response pulse after release; a subsequent read completes normally.
6. Hold req_valid=1 continuously with changing req_addr (0x1, 0x2, 0x3).
   -> exactly one accept per IDLE cycle, 3-cycle spacing, paddr matches the value sampled at each accept.
